// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// the MEM stage (16-bit word/byte accesses) and a 128-bit line memory port.
module dcache_responder #(
    parameter int NUM_SETS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [15:0]    mem_address,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic [15:0]    mem_wdata,
    input  logic [1:0]     mem_byte_enable,
    output logic [15:0]    mem_rdata,
    output logic           dcache_resp,
    output logic [15:0]    pmem_address,
    output logic           pmem_read,
    output logic           pmem_write,
    output logic [127:0]   pmem_wdata,
    output logic [15:0]    pmem_byte_enable,
    input  logic [127:0]   pmem_rdata,
    input  logic           pmem_resp
);

    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = 12 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Merge the enabled bytes of a store into an existing cached word.
    function automatic logic [15:0] merge_bytes(input logic [15:0] old_word,
                                                input logic [15:0] new_word,
                                                input logic [1:0]  be);
        logic [15:0] res;
        res[15:8] = be[1] ? new_word[15:8] : old_word[15:8];
        res[7:0]  = be[0] ? new_word[7:0]  : old_word[7:0];
        return res;
    endfunction

    state_t state_r, state_s;

    logic [NUM_SETS-1:0] valid_r;
    logic [TAG_W-1:0]    tag_arr_r  [NUM_SETS];
    logic [127:0]        line_arr_r [NUM_SETS];

    logic [15:1] addr_r;
    logic [15:0] wdata_r;
    logic [1:0]  be_r;

    // Byte address bit 0 is irrelevant: all accesses are word-granular.
    logic unused_addr_lsb_s;
    assign unused_addr_lsb_s = mem_address[0];

    logic               req_s;
    logic [1:0]         be_eff_s;
    logic [INDEX_W-1:0] req_index_s, cap_index_s;
    logic [TAG_W-1:0]   req_tag_s, cap_tag_s;
    logic [2:0]         req_off_s, cap_off_s;
    logic               read_hit_s, cap_hit_s;
    logic [15:0]        hit_word_s, cap_word_s;

    assign req_s       = mem_read | mem_write;
    assign be_eff_s    = (mem_byte_enable == 2'b00) ? 2'b11 : mem_byte_enable;
    assign req_index_s = mem_address[4 +: INDEX_W];
    assign req_tag_s   = mem_address[15 -: TAG_W];
    assign req_off_s   = mem_address[3:1];
    assign cap_index_s = addr_r[4 +: INDEX_W];
    assign cap_tag_s   = addr_r[15 -: TAG_W];
    assign cap_off_s   = addr_r[3:1];

    assign read_hit_s = valid_r[req_index_s] && (tag_arr_r[req_index_s] == req_tag_s);
    assign cap_hit_s  = valid_r[cap_index_s] && (tag_arr_r[cap_index_s] == cap_tag_s);
    assign hit_word_s = line_arr_r[req_index_s][{req_off_s, 4'b0000} +: 16];
    assign cap_word_s = line_arr_r[cap_index_s][{cap_off_s, 4'b0000} +: 16];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a simultaneous read and write is handled as a write.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!req_s) begin
                    state_s = IDLE;
                end else if (mem_write) begin
                    state_s = WRITE;
                end else if (read_hit_s) begin
                    state_s = RESP;
                end else begin
                    state_s = FILL;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    state_s = RESP;
                end else begin
                    state_s = FILL;
                end
            end
            WRITE: begin
                if (pmem_resp) begin
                    state_s = RESP;
                end else begin
                    state_s = WRITE;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Request capture, registered outputs and valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r           <= 15'h0000;
            wdata_r          <= 16'h0000;
            be_r             <= 2'b00;
            valid_r          <= {NUM_SETS{1'b0}};
            mem_rdata        <= 16'h0000;
            dcache_resp      <= 1'b0;
            pmem_address     <= 16'h0000;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_wdata       <= 128'h0;
            pmem_byte_enable <= 16'h0000;
        end else begin
            pmem_read   <= (state_s == FILL);
            pmem_write  <= (state_s == WRITE);
            dcache_resp <= (state_s == RESP);
            if ((state_r == IDLE) && req_s) begin
                addr_r           <= mem_address[15:1];
                wdata_r          <= mem_wdata;
                be_r             <= be_eff_s;
                pmem_address     <= {mem_address[15:4], 4'h0};
                pmem_wdata       <= {8{mem_wdata}};
                pmem_byte_enable <= mem_write ? ({14'h0000, be_eff_s} << {req_off_s, 1'b0})
                                              : 16'h0000;
                if (!mem_write && read_hit_s) begin
                    mem_rdata <= hit_word_s;
                end
            end else if ((state_r == FILL) && pmem_resp) begin
                valid_r[cap_index_s] <= 1'b1;
                mem_rdata            <= pmem_rdata[{cap_off_s, 4'b0000} +: 16];
            end
        end
    end

    // Tag and line storage; contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if ((state_r == FILL) && pmem_resp) begin
            tag_arr_r[cap_index_s]  <= cap_tag_s;
            line_arr_r[cap_index_s] <= pmem_rdata;
        end else if ((state_r == WRITE) && pmem_resp && cap_hit_s) begin
            line_arr_r[cap_index_s][{cap_off_s, 4'b0000} +: 16] <=
                merge_bytes(cap_word_s, wdata_r, be_r);
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: a reference memory predicts read
// data (queued at issue, compared at dcache_resp) and a separate pmem model
// answers line fills and applies write-through traffic.
module tb_dcache_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_wdata;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_rdata;
    logic         dcache_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [15:0]  pmem_byte_enable;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    dcache_responder #(.NUM_SETS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .dcache_resp(dcache_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0]  exp_q [$];
    logic [127:0] pm      [int];
    logic [127:0] ref_mem [int];
    logic [15:0]  last_rdata = 16'h0000;

    function automatic logic [127:0] init_line(input int key);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[16*w +: 16] = 16'(key * 8 + w) ^ 16'hA5C3;
        return l;
    endfunction

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and act as pmem until dcache_resp (bounded).
    task automatic run_req(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                           input logic [1:0] be,
                           output int resp_cyc, output int presp_cyc,
                           output bit saw_pread, output bit saw_pwrite,
                           output logic [15:0] paddr, output logic [15:0] pbe,
                           output logic [127:0] pwdata);
        int key, k2, pm_cnt;
        bit done;
        logic [127:0] line;
        logic [1:0] be_eff;
        logic [15:0] e;
        resp_cyc = 0; presp_cyc = -10; saw_pread = 1'b0; saw_pwrite = 1'b0;
        paddr = 16'h0000; pbe = 16'h0000; pwdata = 128'h0;
        key = int'(addr[15:4]);
        if (!ref_mem.exists(key)) ref_mem[key] = init_line(key);
        if (wr) begin
            be_eff = (be == 2'b00) ? 2'b11 : be;
            line = ref_mem[key];
            if (be_eff[1]) line[16*addr[3:1] + 8 +: 8] = wd[15:8];
            if (be_eff[0]) line[16*addr[3:1] +: 8]     = wd[7:0];
            ref_mem[key] = line;
        end else begin
            line = ref_mem[key];
            exp_q.push_back(line[16*addr[3:1] +: 16]);
        end
        @(negedge clk);
        mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
        mem_read = !wr; mem_write = wr;
        pm_cnt = 0; done = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (dcache_resp) begin
                resp_cyc = cyc; done = 1'b1;
                if (wr) begin
                    check_value("wr_rdata_hold", mem_rdata, last_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check_value("rdata", mem_rdata, e);
                    last_rdata = e;
                end
                mem_read = 1'b0; mem_write = 1'b0;
            end else if (pmem_read || pmem_write) begin
                saw_pread  = saw_pread  | pmem_read;
                saw_pwrite = saw_pwrite | pmem_write;
                paddr = pmem_address; pbe = pmem_byte_enable; pwdata = pmem_wdata;
                pm_cnt++;
                if (pm_cnt == 2) begin
                    k2 = int'(pmem_address[15:4]);
                    if (!pm.exists(k2)) pm[k2] = init_line(k2);
                    if (pmem_write) begin
                        line = pm[k2];
                        for (int b = 0; b < 16; b++)
                            if (pmem_byte_enable[b]) line[8*b +: 8] = pmem_wdata[8*b +: 8];
                        pm[k2] = line;
                    end
                    pmem_rdata = pm[k2];
                    pmem_resp  = 1'b1;
                    presp_cyc  = cyc;
                end
            end
        end
        if (!done) begin
            check_value("resp_timeout", done, 1'b1);
            mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        end
    endtask

    initial begin
        int rc, pc;
        bit sr, sw;
        logic [15:0] pa, pb, ra, rd;
        logic [127:0] pw, l;
        bit rwr;

        rst_n = 1'b0; mem_address = 16'h0000; mem_read = 1'b0; mem_write = 1'b0;
        mem_wdata = 16'h0000; mem_byte_enable = 2'b00; pmem_rdata = 128'h0; pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        check_value("rst_resp", dcache_resp, 1'b0);
        check_value("rst_pread", pmem_read, 1'b0);
        check_value("rst_pwrite", pmem_write, 1'b0);
        check_value("rst_rdata", mem_rdata, 16'h0000);
        check_value("rst_paddr", pmem_address, 16'h0000);
        rst_n = 1'b1;

        // Cold read miss with a known word
        l = init_line(32'h123); l[47:32] = 16'hBEEF;
        pm[32'h123] = l; ref_mem[32'h123] = l;
        run_req(1'b0, 16'h1234, 16'h0000, 2'b00, rc, pc, sr, sw, pa, pb, pw);
        check_value("miss_pread", sr, 1'b1);
        check_value("miss_paddr", pa, 16'h1230);
        check_value("miss_lat", rc, pc + 1);
        check_value("miss_beef", mem_rdata, 16'hBEEF);

        // Repeat read hits
        run_req(1'b0, 16'h1234, 16'h0000, 2'b00, rc, pc, sr, sw, pa, pb, pw);
        check_value("hit_no_pread", sr, 1'b0);
        check_value("hit_lat", rc, 1);

        // Conflict eviction and refetch
        run_req(1'b0, 16'h1A34, 16'h0000, 2'b00, rc, pc, sr, sw, pa, pb, pw);
        check_value("conf_pread", sr, 1'b1);
        check_value("conf_paddr", pa, 16'h1A30);
        run_req(1'b0, 16'h1234, 16'h0000, 2'b00, rc, pc, sr, sw, pa, pb, pw);
        check_value("refetch_pread", sr, 1'b1);

        // Word write hit
        run_req(1'b1, 16'h1236, 16'hCAFE, 2'b11, rc, pc, sr, sw, pa, pb, pw);
        check_value("ww_pwrite", sw, 1'b1);
        check_value("ww_pbe", pb, 16'h00C0);
        check_value("ww_pwdata", pw, {8{16'hCAFE}});
        check_value("ww_lat", rc, pc + 1);
        run_req(1'b0, 16'h1236, 16'h0000, 2'b00, rc, pc, sr, sw, pa, pb, pw);
        check_value("ww_rd_hit", sr, 1'b0);
        check_value("ww_rd_val", mem_rdata, 16'hCAFE);

        // Byte write hit, high byte only
        run_req(1'b1, 16'h1237, 16'h5A5A, 2'b10, rc, pc, sr, sw, pa, pb, pw);
        check_value("bw_pbe", pb, 16'h0080);
        run_req(1'b0, 16'h1236, 16'h0000, 2'b00, rc, pc, sr, sw, pa, pb, pw);
        check_value("bw_rd_hit", sr, 1'b0);
        check_value("bw_rd_val", mem_rdata, 16'h5AFE);

        // Write miss (be=00 means both bytes) does not allocate
        run_req(1'b1, 16'h4000, 16'h1357, 2'b00, rc, pc, sr, sw, pa, pb, pw);
        check_value("wm_pwrite", sw, 1'b1);
        check_value("wm_pbe", pb, 16'h0003);
        run_req(1'b0, 16'h4000, 16'h0000, 2'b00, rc, pc, sr, sw, pa, pb, pw);
        check_value("wm_rd_miss", sr, 1'b1);
        check_value("wm_rd_val", mem_rdata, 16'h1357);

        // Randomised mix over a few conflicting lines
        for (int i = 0; i < 24; i++) begin
            ra  = 16'h1000 | (16'($urandom_range(0, 3)) << 7) | (16'($urandom_range(0, 1)) << 4)
                  | (16'($urandom_range(0, 7)) << 1);
            rwr = ($urandom_range(0, 2) == 0);
            rd  = 16'($urandom);
            run_req(rwr, ra, rd, 2'($urandom), rc, pc, sr, sw, pa, pb, pw);
        end

        // Reset in the middle of a fill
        run_req(1'b0, 16'h1234, 16'h0000, 2'b00, rc, pc, sr, sw, pa, pb, pw);
        run_req(1'b0, 16'h1234, 16'h0000, 2'b00, rc, pc, sr, sw, pa, pb, pw);
        check_value("pre_rst_hit", sr, 1'b0);
        @(negedge clk);
        mem_address = 16'h0050; mem_read = 1'b1;
        for (int i = 0; i < 5 && !pmem_read; i++) @(negedge clk);
        check_value("fill_active", pmem_read, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_value("rst_fill_pread", pmem_read, 1'b0);
        check_value("rst_fill_resp", dcache_resp, 1'b0);
        check_value("rst_fill_rdata", mem_rdata, 16'h0000);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 16'h0000;
        run_req(1'b0, 16'h1234, 16'h0000, 2'b00, rc, pc, sr, sw, pa, pb, pw);
        check_value("post_rst_miss", sr, 1'b1);
        check_value("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
